// File: rtl/sop_sweeper_if.sv
// Command/result bundle for sop_sweeper: mask programming, sweep start and per-vector results.
interface sop_sweeper_if #(
    parameter int N = 4
);
    localparam int M = 2**N;

    logic           cfg_we;
    logic [M-1:0]   cfg_mask;
    logic           start;
    logic [M-1:0]   exp_mask;
    logic           busy;
    logic           out_valid;
    logic [N-1:0]   out_vec;
    logic           out_s;
    logic           out_mismatch;
    logic           done;
    logic [N:0]     err_count;
    logic [N:0]     ones_count;

    modport master (
        output cfg_we, cfg_mask, start, exp_mask,
        input  busy, out_valid, out_vec, out_s, out_mismatch, done, err_count, ones_count
    );

    modport slave (
        input  cfg_we, cfg_mask, start, exp_mask,
        output busy, out_valid, out_vec, out_s, out_mismatch, done, err_count, ones_count
    );
endinterface

// File: rtl/sop_sweeper.sv
// Programmable N-input sum-of-products held as a minterm mask, swept exhaustively once per start
// and checked against a captured expected truth table.
module sop_sweeper #(
    parameter int N = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    sop_sweeper_if.slave  bus
);
    localparam int M = 2**N;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [M-1:0]   r_mask;
    logic [M-1:0]   r_exp;
    logic [N-1:0]   r_cnt;
    logic [N:0]     r_err_count;
    logic [N:0]     r_ones_count;

    logic           w_accept;
    logic           w_last;
    logic           w_s;
    logic           w_mis;

    assign w_accept = (r_state == S_IDLE) && bus.start;
    assign w_last   = (r_cnt == N'(M-1));

    // Raw function/compare bits; gated by state in the output decode.
    assign w_s   = r_mask[r_cnt];
    assign w_mis = r_mask[r_cnt] ^ r_exp[r_cnt];

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_SWEEP;
            S_SWEEP: if (w_last)    w_next = S_DONE;
            S_DONE:                 w_next = S_IDLE;
            default:                w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy         = (r_state != S_IDLE);
        bus.out_valid    = (r_state == S_SWEEP);
        bus.done         = (r_state == S_DONE);
        bus.out_vec      = '0;
        bus.out_s        = 1'b0;
        bus.out_mismatch = 1'b0;
        if (r_state == S_SWEEP) begin
            bus.out_vec      = r_cnt;
            bus.out_s        = w_s;
            bus.out_mismatch = w_mis;
        end
    end

    // A cfg write coinciding with an accepted start lands on the same edge, so the sweep sees the new mask.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mask       <= '0;
            r_exp        <= '0;
            r_cnt        <= '0;
            r_err_count  <= '0;
            r_ones_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cfg_we) r_mask <= bus.cfg_mask;
                    if (w_accept) begin
                        r_exp        <= bus.exp_mask;
                        r_cnt        <= '0;
                        r_err_count  <= '0;
                        r_ones_count <= '0;
                    end
                end
                S_SWEEP: begin
                    r_ones_count <= r_ones_count + {{N{1'b0}}, w_s};
                    r_err_count  <= r_err_count + {{N{1'b0}}, w_mis};
                    if (!w_last) r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.err_count  = r_err_count;
    assign bus.ones_count = r_ones_count;
endmodule
